// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
// Iterative RV32M multiply/divide unit. A request is accepted in IDLE, runs a
// fixed CYCLES-step shift-add (multiply) or restoring-divide loop on operand
// magnitudes, then presents the signed-corrected result for one DONE cycle.
//
// Build option:
//   MULDIV_DIV_EN  defined   -> all eight M-extension ops are supported.
//                  undefined -> the divider datapath is compiled out; divide
//                               ops go straight to DONE with err=1, result=0
//                               and no register-file write.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   start               request, sampled only in IDLE
//   funct3              M-extension op select (MUL..REMU)
//   rs1_data, rs2_data  operand A (multiplicand/dividend), operand B
//   rd_in               destination register index
//   busy                high from the cycle after accept through DONE
//   done                one-cycle completion pulse
//   rd_we               register-file write strobe (done, rd_out != 0, no err)
//   rd_out              latched destination index
//   result              operation result, held until the next completion
//   err                 one-cycle pulse with done for unsupported ops
// -----------------------------------------------------------------------------
module muldiv_unit #(
  parameter int CYCLES = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  funct3,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic [4:0]  rd_in,
  output logic        busy,
  output logic        done,
  output logic        rd_we,
  output logic [4:0]  rd_out,
  output logic [31:0] result,
  output logic        err
);

  localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [2:0]    op_q;
  logic [4:0]    rd_q;
  logic [31:0]   acc_hi_q, acc_lo_q;  // {product} or {remainder, quotient}
  logic [31:0]   b_q;                 // multiplicand / divisor magnitude
  logic          neg_q;               // final result must be negated
  logic [31:0]   result_q;
`ifdef MULDIV_DIV_EN
  logic          spec_q;              // special case overrides the datapath
  logic [31:0]   spec_val_q;
`else
  logic          err_q;
`endif

  logic accept, last;
  assign accept = (state_q == IDLE) && start;
  assign last   = (state_q == CALC) && (cnt_q == LAST);

  // ---------------------------------------------------------------------------
  // Operand preparation at accept: signedness per op, magnitudes, result sign.
  // ---------------------------------------------------------------------------
  logic        a_signed, b_signed, a_neg, b_neg, neg_d;
  logic [31:0] a_mag, b_mag;

  // NOTE: every always_comb output gets a default before any branch; a path
  // that leaves a variable unassigned would otherwise infer a latch.
  always_comb begin
    a_signed = 1'b0;
    b_signed = 1'b0;
    if (funct3[2]) begin
      // DIV/REM signed, DIVU/REMU unsigned
      a_signed = !funct3[0];
      b_signed = !funct3[0];
    end else begin
      // MUL/MULH signed x signed, MULHSU signed x unsigned, MULHU unsigned
      a_signed = (funct3[1:0] != 2'b11);
      b_signed = !funct3[1];
    end
    a_neg = a_signed && rs1_data[31];
    b_neg = b_signed && rs2_data[31];
    a_mag = a_neg ? -rs1_data : rs1_data;
    b_mag = b_neg ? -rs2_data : rs2_data;
    // Remainder follows the dividend; products and quotients the sign XOR.
    neg_d = (funct3[2] && funct3[1]) ? a_neg : (a_neg ^ b_neg);
  end

`ifdef MULDIV_DIV_EN
  logic        spec_d;
  logic [31:0] spec_val_d;

  always_comb begin
    spec_d     = 1'b0;
    spec_val_d = 32'd0;
    if (funct3[2]) begin
      if (rs2_data == 32'd0) begin
        spec_d     = 1'b1;
        spec_val_d = funct3[1] ? rs1_data : 32'hFFFF_FFFF;
      end else if (!funct3[0] && (rs1_data == 32'h8000_0000) &&
                   (rs2_data == 32'hFFFF_FFFF)) begin
        spec_d     = 1'b1;
        spec_val_d = funct3[1] ? 32'd0 : 32'h8000_0000;
      end
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // One iteration of the loop, computed from the current accumulator.
  // ---------------------------------------------------------------------------
  logic [31:0] step_hi, step_lo;
  logic [32:0] mul_sum;
`ifdef MULDIV_DIV_EN
  logic [32:0] div_shift;
  logic        div_ge;
`endif

  always_comb begin
    step_hi = acc_hi_q;
    step_lo = acc_lo_q;
    // Shift-add: multiplier sits in acc_lo and drains out of bit 0 while the
    // partial product (with its carry) shifts in from the top.
    mul_sum = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, b_q} : 33'd0);
`ifdef MULDIV_DIV_EN
    // Restoring divide: shift {rem, dividend} left, trial-subtract divisor.
    div_shift = {acc_hi_q, acc_lo_q[31]};
    div_ge    = (div_shift >= {1'b0, b_q});
`endif
    if (!op_q[2]) begin
      step_hi = mul_sum[32:1];
      step_lo = {mul_sum[0], acc_lo_q[31:1]};
    end
`ifdef MULDIV_DIV_EN
    else begin
      // Either branch leaves a value below the divisor, so 32 bits suffice.
      step_hi = div_ge ? 32'(div_shift - {1'b0, b_q}) : div_shift[31:0];
      step_lo = {acc_lo_q[30:0], div_ge};
    end
`endif
  end

  // Final value taken from the last iteration, sign-corrected.
  logic [63:0] prod;
  logic [31:0] fin;

  always_comb begin
    prod = {step_hi, step_lo};
    if (neg_q) prod = -prod;
    fin = (op_q[1:0] == 2'b00) ? prod[31:0] : prod[63:32];
`ifdef MULDIV_DIV_EN
    if (op_q[2]) begin
      if (spec_q)        fin = spec_val_q;
      else if (op_q[1])  fin = neg_q ? -step_hi : step_hi;
      else               fin = neg_q ? -step_lo : step_lo;
    end
`endif
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and outputs.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    busy    = (state_q != IDLE);
    done    = (state_q == DONE);
`ifdef MULDIV_DIV_EN
    rd_we   = done && (rd_q != 5'd0);
    err     = 1'b0;
`else
    rd_we   = done && (rd_q != 5'd0) && !err_q;
    err     = done && err_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
`ifdef MULDIV_DIV_EN
          state_d = CALC;
`else
          state_d = funct3[2] ? DONE : CALC;
`endif
        end
      end
      CALC:    if (cnt_q == LAST) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and datapath registers.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      op_q       <= 3'd0;
      rd_q       <= 5'd0;
      acc_hi_q   <= 32'd0;
      acc_lo_q   <= 32'd0;
      b_q        <= 32'd0;
      neg_q      <= 1'b0;
      result_q   <= 32'd0;
`ifdef MULDIV_DIV_EN
      spec_q     <= 1'b0;
      spec_val_q <= 32'd0;
`else
      err_q      <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      if (accept) begin
        cnt_q    <= '0;
        op_q     <= funct3;
        rd_q     <= rd_in;
        acc_hi_q <= 32'd0;
        acc_lo_q <= a_mag;
        b_q      <= b_mag;
        neg_q    <= neg_d;
`ifdef MULDIV_DIV_EN
        spec_q     <= spec_d;
        spec_val_q <= spec_val_d;
`else
        err_q <= funct3[2];
        if (funct3[2]) result_q <= 32'd0;
`endif
      end else if (state_q == CALC) begin
        cnt_q    <= cnt_q + CW'(1);
        acc_hi_q <= step_hi;
        acc_lo_q <= step_lo;
        if (last) result_q <= fin;
      end
    end
  end

  assign rd_out = rd_q;
  assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_muldiv_unit
// Scoreboard bench for muldiv_unit. The driver issues requests and pushes the
// expected completion into a queue; an independent monitor pops and compares
// whenever done is seen. Expected values come from spec-level constants for
// the directed vectors and from a plain-arithmetic RV32M model for random ops.
// -----------------------------------------------------------------------------
module tb_muldiv_unit;

`ifdef MULDIV_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] rs1_data, rs2_data;
  logic [4:0]  rd_in;
  logic        busy, done, rd_we, err;
  logic [4:0]  rd_out;
  logic [31:0] result;

  muldiv_unit #(.CYCLES(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .funct3   (funct3),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .rd_in    (rd_in),
    .busy     (busy),
    .done     (done),
    .rd_we    (rd_we),
    .rd_out   (rd_out),
    .result   (result),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] res;
    logic        we;
    logic        err;
    logic [4:0]  rd;
  } exp_t;

  typedef struct packed {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] res;
  } vec_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  // RV32M reference computed with wide signed/unsigned arithmetic.
  function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] b);
    longint      sa, sb_, ub, p;
    logic [63:0] up;
    int          ia, ib;
    sa  = longint'(signed'(a));
    sb_ = longint'(signed'(b));
    ub  = longint'({32'd0, b});
    ia  = signed'(a);
    ib  = signed'(b);
    case (f3)
      3'd0: begin p = sa * sb_; return p[31:0]; end
      3'd1: begin p = sa * sb_; return p[63:32]; end
      3'd2: begin p = sa * ub;  return p[63:32]; end
      3'd3: begin up = {32'd0, a} * {32'd0, b}; return up[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'(ia / ib);
      end
      3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return 32'(ia % ib);
      end
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  function automatic logic [31:0] rand_op();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // Monitor: compare every completion against the oldest expected entry.
  exp_t mon_e;
  always @(negedge clk) begin
    if (!reset) begin
      if (done) begin
        if (sb.size() == 0) begin
          check("done_without_request", 32'(done), 32'd0);
        end else begin
          mon_e = sb.pop_front();
          check("result", result, mon_e.res);
          check("rd_we", 32'(rd_we), 32'(mon_e.we));
          check("err", 32'(err), 32'(mon_e.err));
          check("rd_out", 32'(rd_out), 32'(mon_e.rd));
        end
      end else if (rd_we || err) begin
        check("strobe_without_done", 32'({rd_we, err}), 32'd0);
      end
    end
  end

  // Issue one request; poke >= 0 pulses start again that many cycles in.
  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] exp_res, input int poke);
    exp_t e;
    int   k;
    int   busy_n;
    e.err = f3[2] && !DIV_EN;
    e.res = e.err ? 32'd0 : exp_res;
    e.we  = !e.err && (rd != 5'd0);
    e.rd  = rd;
    check("idle_before_start", 32'(busy), 32'd0);
    funct3   = f3;
    rs1_data = a;
    rs2_data = b;
    rd_in    = rd;
    start    = 1'b1;
    sb.push_back(e);
    @(posedge clk); #1;
    // Operands may change freely once accepted.
    start    = 1'b0;
    rs1_data = $urandom;
    rs2_data = $urandom;
    rd_in    = 5'($urandom);
    funct3   = 3'($urandom);
    k = 0;
    busy_n = 0;
    while (!done && k < 100) begin
      if (busy) busy_n++;
      start = (k == poke);
      @(posedge clk); #1;
      k++;
    end
    start = 1'b0;
    if (busy) busy_n++;
    check("done_latency", 32'(k), e.err ? 32'd0 : 32'd32);
    check("busy_cycles", 32'(busy_n), e.err ? 32'd1 : 32'd33);
    @(posedge clk); #1;
    check("busy_release", 32'(busy), 32'd0);
    check("result_hold", result, e.res);
  endtask

  vec_t vecs [13] = '{
    '{3'd0, 32'd7,          32'hFFFF_FFFD, 5'd1,  32'hFFFF_FFEB},
    '{3'd1, 32'h8000_0000,  32'h8000_0000, 5'd2,  32'h4000_0000},
    '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd3,  32'hFFFF_FFFE},
    '{3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd4,  32'hFFFF_FFFF},
    '{3'd4, 32'hFFFF_FFF9,  32'd2,         5'd5,  32'hFFFF_FFFD},
    '{3'd6, 32'hFFFF_FFF9,  32'd2,         5'd6,  32'hFFFF_FFFF},
    '{3'd5, 32'd100,        32'd7,         5'd7,  32'd14},
    '{3'd7, 32'd100,        32'd7,         5'd8,  32'd2},
    '{3'd5, 32'd5,          32'd0,         5'd9,  32'hFFFF_FFFF},
    '{3'd7, 32'd5,          32'd0,         5'd10, 32'd5},
    '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 5'd11, 32'h8000_0000},
    '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 5'd12, 32'd0},
    '{3'd0, 32'd2,          32'd3,         5'd0,  32'd6}
  };

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          k, first, second;
    logic [2:0]  f3;
    logic [31:0] a, b;
    exp_t        e;

    reset    = 1'b1;
    start    = 1'b0;
    funct3   = 3'd0;
    rs1_data = 32'd0;
    rs2_data = 32'd0;
    rd_in    = 5'd0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy",   32'(busy),   32'd0);
    check("reset_done",   32'(done),   32'd0);
    check("reset_rd_we",  32'(rd_we),  32'd0);
    check("reset_err",    32'(err),    32'd0);
    check("reset_rd_out", 32'(rd_out), 32'd0);
    check("reset_result", result,      32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    foreach (vecs[i])
      issue(vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].res, -1);

    // Abort mid-CALC: leave a nonzero result/rd behind first.
    issue(3'd0, 32'h1234, 32'd3, 5'd3, 32'h369C, -1);
    funct3   = 3'd0;
    rs1_data = 32'd9;
    rs2_data = 32'd9;
    rd_in    = 5'd7;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort_busy",   32'(busy),   32'd0);
    check("abort_done",   32'(done),   32'd0);
    check("abort_rd_we",  32'(rd_we),  32'd0);
    check("abort_rd_out", 32'(rd_out), 32'd0);
    check("abort_result", result,      32'd0);
    repeat (40) @(posedge clk);
    #1;
    check("abort_stays_idle", 32'(busy), 32'd0);

    // MUL 3 x 4 after the abort, with a stray start while busy.
    issue(3'd0, 32'd3, 32'd4, 5'd9, 32'd12, 5);

    // start held high: two back-to-back MULHU ops, 34 cycles apart.
    a = 32'hDEAD_BEEF;
    b = 32'h1234_5678;
    e.res = ref_result(3'd3, a, b);
    e.we  = 1'b1;
    e.err = 1'b0;
    e.rd  = 5'd12;
    sb.push_back(e);
    sb.push_back(e);
    funct3   = 3'd3;
    rs1_data = a;
    rs2_data = b;
    rd_in    = 5'd12;
    start    = 1'b1;
    k = 0;
    first = -1;
    second = -1;
    while (second < 0 && k < 200) begin
      @(posedge clk); #1;
      k++;
      if (done) begin
        if (first < 0) first = k;
        else           second = k;
      end
    end
    start = 1'b0;
    check("b2b_period", 32'(second - first), 32'd34);
    @(posedge clk); #1;
    check("b2b_release", 32'(busy), 32'd0);

    // Randomized ops against the reference model.
    for (int i = 0; i < 40; i++) begin
      f3 = 3'($urandom_range(0, 7));
      a  = rand_op();
      b  = rand_op();
      issue(f3, a, b, 5'($urandom_range(0, 31)), ref_result(f3, a, b), -1);
    end

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
